test_stream_gen: RTL and testbench

TEST_STREAM_GEN -- requirements
Module: test_stream_gen

---
 rtl/test_stream_gen_pkg.sv | 30 +++
 rtl/test_stream_lfsr.sv | 21 ++
 rtl/test_stream_gen.sv | 227 ++++++++++++++++++++++
 tb/tb_test_stream_gen.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/test_stream_gen_pkg.sv
// Shared types and constants for the test stream generator.
// Mode and state encodings plus the default Galois LFSR tap mask.
package test_stream_gen_pkg;

  typedef enum logic [1:0] {
    MODE_INCR  = 2'd0,
    MODE_LFSR  = 2'd1,
    MODE_CONST = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [15:0] LFSR_POLY_DEFAULT = 16'hB400;

  // The reserved encoding falls back to incrementing data.
  function automatic mode_e decode_mode(input logic [1:0] raw);
    mode_e m;
    case (raw)
      2'd1:    m = MODE_LFSR;
      2'd2:    m = MODE_CONST;
      default: m = MODE_INCR;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/test_stream_lfsr.sv
// One combinational step of a right-shifting Galois LFSR.
module test_stream_lfsr
  import test_stream_gen_pkg::*;
#(
  parameter int                DWIDTH = 16,
  parameter logic [DWIDTH-1:0] POLY   = DWIDTH'(LFSR_POLY_DEFAULT)
) (
  input  logic [DWIDTH-1:0] state,
  output logic [DWIDTH-1:0] next_state
);

  // Shift right and fold in the tap mask when a one falls out.
  always_comb begin
    if (state[0]) begin
      next_state = (state >> 1) ^ POLY;
    end else begin
      next_state = state >> 1;
    end
  end

endmodule

// File: rtl/test_stream_gen.sv
// Multi-channel packetised test pattern source (INCR / LFSR / CONST data).
// Define TEST_STREAM_GEN_BEAT_CNT_EN to add the 32-bit beat_cnt transfer counter.
module test_stream_gen
  import test_stream_gen_pkg::*;
#(
  parameter int                DWIDTH    = 16,
  parameter int                CHANNELS  = 4,
  parameter int                LEN_W     = 8,
  parameter logic [DWIDTH-1:0] LFSR_POLY = DWIDTH'(LFSR_POLY_DEFAULT),
  localparam int               CHAN_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [1:0]          cfg_mode,
  input  logic [DWIDTH-1:0]   cfg_seed,
  input  logic [LEN_W-1:0]    cfg_len,
  input  logic [CHANNELS-1:0] cfg_chan_mask,
  output logic [DWIDTH-1:0]   dout_data,
  output logic                dout_valid,
  input  logic                dout_ready,
  output logic                dout_last,
  output logic [CHAN_W-1:0]   dout_chan,
  output logic                busy,
  output logic                done
`ifdef TEST_STREAM_GEN_BEAT_CNT_EN
  ,
  output logic [31:0]         beat_cnt
`endif
);

  localparam logic [DWIDTH-1:0] ONE_D = {{(DWIDTH-1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0]  ONE_L = {{(LEN_W-1){1'b0}}, 1'b1};

  state_e              state_r, state_s;
  mode_e               mode_r, mode_s;
  logic [DWIDTH-1:0]   seed_r, seed_s;
  logic [LEN_W-1:0]    len_r, len_s;
  logic [CHANNELS-1:0] mask_r, mask_s;
  logic [LEN_W-1:0]    beat_idx_r, beat_idx_s;
  logic [DWIDTH-1:0]   data_r, data_s;
  logic                valid_r, valid_s;
  logic                last_r, last_s;
  logic [CHAN_W-1:0]   chan_r, chan_s;
  logic                busy_r, busy_s;
  logic                done_r, done_s;

  logic                xfer_s;
  logic [CHAN_W-1:0]   first_chan_s;
  logic [CHAN_W-1:0]   next_chan_s;
  logic                has_next_s;
  logic [DWIDTH-1:0]   first_data_s;
  logic [DWIDTH-1:0]   lfsr_next_s;

  assign xfer_s = valid_r & dout_ready;

  // The LFSR always steps from the beat on the bus, so its state carries across channels.
  test_stream_lfsr #(
    .DWIDTH (DWIDTH),
    .POLY   (LFSR_POLY)
  ) u_lfsr (
    .state      (data_r),
    .next_state (lfsr_next_s)
  );

  // Lowest enabled channel for a new run, and next enabled channel above the current one.
  always_comb begin
    first_chan_s = {CHAN_W{1'b0}};
    next_chan_s  = {CHAN_W{1'b0}};
    has_next_s   = 1'b0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (cfg_chan_mask[i]) begin
        first_chan_s = CHAN_W'(i);
      end else begin
        first_chan_s = first_chan_s;
      end
      if (mask_r[i] && (CHAN_W'(i) > chan_r)) begin
        next_chan_s = CHAN_W'(i);
        has_next_s  = 1'b1;
      end else begin
        has_next_s  = has_next_s;
      end
    end
  end

  // Data of the very first beat, taken straight from the configuration inputs.
  always_comb begin
    case (decode_mode(cfg_mode))
      MODE_LFSR:  first_data_s = (cfg_seed == {DWIDTH{1'b0}}) ? ONE_D : cfg_seed;
      MODE_CONST: first_data_s = cfg_seed;
      default:    first_data_s = cfg_seed + DWIDTH'(first_chan_s);
    endcase
  end

  // Run sequencing: next state and next registered outputs.
  always_comb begin
    state_s    = state_r;
    mode_s     = mode_r;
    seed_s     = seed_r;
    len_s      = len_r;
    mask_s     = mask_r;
    beat_idx_s = beat_idx_r;
    data_s     = data_r;
    valid_s    = valid_r;
    last_s     = last_r;
    chan_s     = chan_r;
    busy_s     = busy_r;
    done_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          mode_s = decode_mode(cfg_mode);
          seed_s = cfg_seed;
          len_s  = cfg_len;
          mask_s = cfg_chan_mask;
          busy_s = 1'b1;
          if ((cfg_chan_mask != {CHANNELS{1'b0}}) && (cfg_len != {LEN_W{1'b0}})) begin
            state_s    = ST_SEND;
            valid_s    = 1'b1;
            chan_s     = first_chan_s;
            beat_idx_s = {LEN_W{1'b0}};
            data_s     = first_data_s;
            last_s     = (cfg_len == ONE_L);
          end else begin
            state_s = ST_DONE;
            done_s  = 1'b1;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (xfer_s && last_r && has_next_s) begin
          chan_s     = next_chan_s;
          beat_idx_s = {LEN_W{1'b0}};
          last_s     = (len_r == ONE_L);
          case (mode_r)
            MODE_LFSR:  data_s = lfsr_next_s;
            MODE_CONST: data_s = seed_r;
            default:    data_s = seed_r + DWIDTH'(next_chan_s);
          endcase
        end else if (xfer_s && last_r) begin
          state_s = ST_DONE;
          valid_s = 1'b0;
          last_s  = 1'b0;
          done_s  = 1'b1;
        end else if (xfer_s) begin
          beat_idx_s = beat_idx_r + ONE_L;
          last_s     = ((beat_idx_r + ONE_L) == (len_r - ONE_L));
          case (mode_r)
            MODE_LFSR:  data_s = lfsr_next_s;
            MODE_CONST: data_s = seed_r;
            default:    data_s = data_r + ONE_D;
          endcase
        end else begin
          state_s = ST_SEND;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
        busy_s  = 1'b0;
      end
      default: begin
        state_s = ST_IDLE;
        valid_s = 1'b0;
        last_s  = 1'b0;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any packet in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      mode_r     <= MODE_INCR;
      seed_r     <= {DWIDTH{1'b0}};
      len_r      <= {LEN_W{1'b0}};
      mask_r     <= {CHANNELS{1'b0}};
      beat_idx_r <= {LEN_W{1'b0}};
      data_r     <= {DWIDTH{1'b0}};
      valid_r    <= 1'b0;
      last_r     <= 1'b0;
      chan_r     <= {CHAN_W{1'b0}};
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      mode_r     <= mode_s;
      seed_r     <= seed_s;
      len_r      <= len_s;
      mask_r     <= mask_s;
      beat_idx_r <= beat_idx_s;
      data_r     <= data_s;
      valid_r    <= valid_s;
      last_r     <= last_s;
      chan_r     <= chan_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
    end
  end

  assign dout_data  = data_r;
  assign dout_valid = valid_r;
  assign dout_last  = last_r;
  assign dout_chan  = chan_r;
  assign busy       = busy_r;
  assign done       = done_r;

`ifdef TEST_STREAM_GEN_BEAT_CNT_EN
  logic [31:0] beat_cnt_r;

  // Free-running transfer count, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_r <= 32'd0;
    end else if (xfer_s) begin
      beat_cnt_r <= beat_cnt_r + 32'd1;
    end else begin
      beat_cnt_r <= beat_cnt_r;
    end
  end

  assign beat_cnt = beat_cnt_r;
`endif

endmodule

// File: tb/tb_test_stream_gen.sv
// Randomised bench for test_stream_gen: a run-level reference model expands each
// accepted start into its expected beat list, and literal sequences pin the model.
module tb_test_stream_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  cfg_mode = 2'd0;
  logic [15:0] cfg_seed = 16'd0;
  logic [7:0]  cfg_len = 8'd0;
  logic [3:0]  cfg_chan_mask = 4'd0;
  logic        dout_ready = 1'b0;
  logic [15:0] dout_data;
  logic        dout_valid;
  logic        dout_last;
  logic [1:0]  dout_chan;
  logic        busy;
  logic        done;
`ifdef TEST_STREAM_GEN_BEAT_CNT_EN
  logic [31:0] beat_cnt;
`endif

  test_stream_gen dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .cfg_mode      (cfg_mode),
    .cfg_seed      (cfg_seed),
    .cfg_len       (cfg_len),
    .cfg_chan_mask (cfg_chan_mask),
    .dout_data     (dout_data),
    .dout_valid    (dout_valid),
    .dout_ready    (dout_ready),
    .dout_last     (dout_last),
    .dout_chan     (dout_chan),
    .busy          (busy),
    .done          (done)
`ifdef TEST_STREAM_GEN_BEAT_CNT_EN
    ,
    .beat_cnt      (beat_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] data;
    logic        last;
    logic [1:0]  chan;
  } beat_t;

  int          tests_run = 0;
  int          tests_failed = 0;
  bit          checking = 1'b0;
  int          phase = 0;        // 0 idle, 1 emitting beats, 2 done cycle
  beat_t       exp_q[$];
  logic [15:0] obs[$];
  logic [15:0] lit_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Expand one accepted run into the ordered list of beats it must produce.
  function automatic void build_run(input logic [1:0] m, input logic [15:0] seed,
                                    input logic [7:0] len, input logic [3:0] mask);
    logic [15:0] s;
    logic [15:0] d;
    s = (m == 2'd1 && seed == 16'h0000) ? 16'h0001 : seed;
    for (int c = 0; c < 4; c++) begin
      if (mask[c]) begin
        for (int b = 0; b < int'(len); b++) begin
          if (m == 2'd1) begin
            d = s;
            s = lfsr_step(s);
          end else if (m == 2'd2) begin
            d = seed;
          end else begin
            d = seed + 16'(c) + 16'(b);
          end
          exp_q.push_back('{data: d, last: (b == int'(len) - 1), chan: 2'(c)});
        end
      end
    end
  endfunction

  // Reference model, advanced on each rising edge from the bench's own inputs.
  always @(posedge clk) begin
    if (!rst_n) begin
      phase <= 0;
      exp_q.delete();
    end else begin
      case (phase)
        0: if (start) begin
          build_run(cfg_mode, cfg_seed, cfg_len, cfg_chan_mask);
          phase <= (exp_q.size() == 0) ? 2 : 1;
        end
        1: if (dout_ready) begin
          void'(exp_q.pop_front());
          phase <= (exp_q.size() == 0) ? 2 : 1;
        end
        default: phase <= 0;
      endcase
    end
  end

  // Compare DUT outputs with the model every cycle, mid-way between edges.
  always @(negedge clk) begin
    if (checking) begin
      if (!rst_n) begin
        chk("rst_valid", 32'(dout_valid), 32'd0);
        chk("rst_last",  32'(dout_last),  32'd0);
        chk("rst_busy",  32'(busy),       32'd0);
        chk("rst_done",  32'(done),       32'd0);
        chk("rst_data",  32'(dout_data),  32'd0);
        chk("rst_chan",  32'(dout_chan),  32'd0);
      end else begin
        chk("valid", 32'(dout_valid), 32'(phase == 1));
        chk("busy",  32'(busy),       32'(phase != 0));
        chk("done",  32'(done),       32'(phase == 2));
        if (phase == 1 && exp_q.size() > 0) begin
          chk("data", 32'(dout_data), 32'(exp_q[0].data));
          chk("last", 32'(dout_last), 32'(exp_q[0].last));
          chk("chan", 32'(dout_chan), 32'(exp_q[0].chan));
        end
        if (dout_valid && dout_ready) obs.push_back(dout_data);
      end
    end
  end

  task automatic chk_obs(input string nm);
    chk($sformatf("%s_count", nm), 32'(obs.size()), 32'(lit_q.size()));
    for (int i = 0; i < obs.size() && i < lit_q.size(); i++)
      chk($sformatf("%s_beat%0d", nm, i), 32'(obs[i]), 32'(lit_q[i]));
  endtask

  // One run: pulse start, then shape ready (0 always, 1 toggling, 2 random + stray starts).
  task automatic do_run(input logic [1:0] m, input logic [15:0] seed, input logic [7:0] len,
                        input logic [3:0] mask, input int rmode);
    obs.delete();
    @(posedge clk); #1;
    cfg_mode = m; cfg_seed = seed; cfg_len = len; cfg_chan_mask = mask;
    start = 1'b1; dout_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cfg_mode = 2'($urandom); cfg_seed = 16'($urandom);
    cfg_len = 8'($urandom); cfg_chan_mask = 4'($urandom);
    for (int k = 0; k < 400; k++) begin
      if (phase == 0) break;
      case (rmode)
        0: dout_ready = 1'b1;
        1: dout_ready = (k % 2 == 0);
        default: begin
          dout_ready = 1'($urandom_range(0, 1));
          start = ($urandom_range(0, 4) == 0);
        end
      endcase
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk("run_end_idle", 32'(phase), 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    checking = 1'b1;
    #1;
    chk("reset_valid", 32'(dout_valid), 32'd0);
    chk("reset_busy",  32'(busy),       32'd0);
    chk("reset_done",  32'(done),       32'd0);
    chk("reset_data",  32'(dout_data),  32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    do_run(2'd0, 16'h0010, 8'd3, 4'b0101, 0);
    lit_q = '{16'h0010, 16'h0011, 16'h0012, 16'h0012, 16'h0013, 16'h0014};
    chk_obs("incr_two_chan");

    do_run(2'd0, 16'hFFFF, 8'd2, 4'b0001, 0);
    lit_q = '{16'hFFFF, 16'h0000};
    chk_obs("incr_wrap");

    do_run(2'd1, 16'h0000, 8'd2, 4'b0001, 0);
    lit_q = '{16'h0001, 16'hB400};
    chk_obs("lfsr_zero_seed");

    do_run(2'd2, 16'hA5A5, 8'd4, 4'b0001, 1);
    lit_q = '{16'hA5A5, 16'hA5A5, 16'hA5A5, 16'hA5A5};
    chk_obs("const_stall");

    do_run(2'd0, 16'h1234, 8'd3, 4'b0000, 0);
    lit_q.delete();
    chk_obs("mask_zero");

    do_run(2'd0, 16'h1234, 8'd0, 4'b1111, 0);
    chk_obs("len_zero");

    do_run(2'd3, 16'h0200, 8'd1, 4'b1010, 0);
    lit_q = '{16'h0201, 16'h0203};
    chk_obs("reserved_as_incr");

    // Reset in the middle of the second beat of a five-beat packet.
    @(posedge clk); #1;
    cfg_mode = 2'd0; cfg_seed = 16'h0100; cfg_len = 8'd5; cfg_chan_mask = 4'b0001;
    start = 1'b1; dout_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("mid_second_beat", 32'(dout_data), 32'h0101);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(dout_valid), 32'd0);
    chk("mid_rst_busy",  32'(busy),       32'd0);
    chk("mid_rst_data",  32'(dout_data),  32'd0);
    chk("mid_rst_last",  32'(dout_last),  32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    do_run(2'd0, 16'h0100, 8'd5, 4'b0001, 0);
    lit_q = '{16'h0100, 16'h0101, 16'h0102, 16'h0103, 16'h0104};
    chk_obs("after_reset");

    for (int r = 0; r < 40; r++) begin
      do_run(2'($urandom_range(0, 3)), 16'($urandom), 8'($urandom_range(0, 6)),
             4'($urandom), $urandom_range(0, 2));
    end

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
